add12u_err_monitor: RTL and testbench

- Sequential measurement block. Consumes a stream of operand pairs together with the 13-bit result of an approximate 12-bit unsigned adder under test, and recomputes the exact sum.
- Accumulates the error statistics we publish per adder: sum of absolute errors (for MAE), sum of squared errors (for MSE), worst-case error (WCE) and erroneous-sample count (for EP).
- Sits on the receive side of the adder-under-test wrapper in the FPGA characterisation harness; host logic reads the results once done is asserted.

---
 rtl/add12u_meas_pkg.sv | 35 +++
 rtl/add12u_err_stage.sv | 88 ++++++++
 rtl/add12u_err_monitor.sv | 143 ++++++++++++++
 tb/tb_add12u_err_monitor.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/add12u_meas_pkg.sv
// Shared definitions for the approximate-adder error monitor.
// Contents: default widths, FSM state enum, and a saturating add helper
// used by both error accumulators.
package add12u_meas_pkg;

  localparam int WIDTH_DEF = 12;
  localparam int CNT_W_DEF = 24;
  localparam int ABS_W_DEF = 40;
  localparam int SQ_W_DEF  = 56;

  // Common working width for sat_add; wide enough for every accumulator.
  localparam int SAT_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } meas_state_e;

  // acc + inc, clamped to the all-ones value of a w-bit accumulator.
  // Callers zero-extend into SAT_W bits and truncate the result back.
  function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] acc,
                                               input logic [SAT_W-1:0] inc,
                                               input int unsigned      w = SAT_W);
    logic [SAT_W:0]   sum;
    logic [SAT_W-1:0] lim;
    sum = {1'b0, acc} + {1'b0, inc};
    if (w >= SAT_W) lim = '1;
    else            lim = (SAT_W'(1) << w) - SAT_W'(1);
    if (sum > {1'b0, lim}) return lim;
    return sum[SAT_W-1:0];
  endfunction

endpackage

// File: rtl/add12u_err_stage.sv
// Two-stage error datapath.
// S1 registers the exact sum and the approximate sum; S2 registers the
// error magnitude, its square and the "erroneous" flag.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid             sample accepted this cycle
//   in_a, in_b, in_o     operands and approximate sum
//   s1_valid, s2_valid   occupancy of each stage
//   s2_d, s2_sq, s2_ne   |exact - in_o|, its square, and (d != 0)
module add12u_err_stage
  import add12u_meas_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_a,
  input  logic [WIDTH-1:0]       in_b,
  input  logic [WIDTH:0]         in_o,
  output logic                   s1_valid,
  output logic                   s2_valid,
  output logic [WIDTH:0]         s2_d,
  output logic [2*(WIDTH+1)-1:0] s2_sq,
  output logic                   s2_ne
);

  localparam int SW = WIDTH + 1;

  logic            s1_valid_q, s1_valid_d;
  logic [SW-1:0]   s1_exact_q, s1_exact_d;
  logic [SW-1:0]   s1_o_q,     s1_o_d;
  logic            s2_valid_q, s2_valid_d;
  logic [SW-1:0]   s2_d_q,     s2_d_d;
  logic [2*SW-1:0] s2_sq_q,    s2_sq_d;
  logic            s2_ne_q,    s2_ne_d;
  logic [SW-1:0]   mag;

  always_comb begin
    s1_valid_d = in_valid;
    s1_exact_d = s1_exact_q;
    s1_o_d     = s1_o_q;
    if (in_valid) begin
      s1_exact_d = SW'(in_a) + SW'(in_b);
      s1_o_d     = in_o;
    end

    // in_o may exceed the exact sum, so take the unsigned magnitude.
    mag = (s1_exact_q >= s1_o_q) ? (s1_exact_q - s1_o_q) : (s1_o_q - s1_exact_q);

    s2_valid_d = s1_valid_q;
    s2_d_d     = s2_d_q;
    s2_sq_d    = s2_sq_q;
    s2_ne_d    = s2_ne_q;
    if (s1_valid_q) begin
      s2_d_d  = mag;
      s2_sq_d = (2*SW)'(mag) * (2*SW)'(mag);
      s2_ne_d = (mag != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_exact_q <= '0;
      s1_o_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_d_q     <= '0;
      s2_sq_q    <= '0;
      s2_ne_q    <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_exact_q <= s1_exact_d;
      s1_o_q     <= s1_o_d;
      s2_valid_q <= s2_valid_d;
      s2_d_q     <= s2_d_d;
      s2_sq_q    <= s2_sq_d;
      s2_ne_q    <= s2_ne_d;
    end
  end

  assign s1_valid = s1_valid_q;
  assign s2_valid = s2_valid_q;
  assign s2_d     = s2_d_q;
  assign s2_sq    = s2_sq_q;
  assign s2_ne    = s2_ne_q;

endmodule

// File: rtl/add12u_err_monitor.sv
// Error-statistics monitor for an approximate WIDTH-bit unsigned adder.
// Accumulates sum |err|, sum err^2, worst-case |err| and erroneous-sample
// count over n_samples accepted samples.
//
// state    | meaning
// ---------+---------------------------------------------------
// ST_IDLE  | after reset, waiting for start
// ST_RUN   | accepting samples until n_samples have been taken
// ST_DRAIN | no accepts, waiting for the datapath to empty
// ST_DONE  | results held stable, start re-arms
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   start, n_samples             launch a run of n_samples samples
//   in_valid, in_ready           sample handshake
//   in_a, in_b, in_o             operands and approximate sum
//   busy, done                   run status
//   abs_sum, sq_sum, wce, err_cnt  error statistics
module add12u_err_monitor
  import add12u_meas_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int ABS_W = ABS_W_DEF,
  parameter int SQ_W  = SQ_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] n_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH:0]   in_o,
  output logic             busy,
  output logic             done,
  output logic [ABS_W-1:0] abs_sum,
  output logic [SQ_W-1:0]  sq_sum,
  output logic [WIDTH:0]   wce,
  output logic [CNT_W-1:0] err_cnt
);

  meas_state_e      state_q, state_d;
  logic [CNT_W-1:0] n_q,     n_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [ABS_W-1:0] abs_q,   abs_d;
  logic [SQ_W-1:0]  sq_q,    sq_d;
  logic [WIDTH:0]   wce_q,   wce_d;
  logic [CNT_W-1:0] err_q,   err_d;

  logic                   accept;
  logic                   s1_valid, s2_valid, s2_ne;
  logic [WIDTH:0]         s2_d;
  logic [2*(WIDTH+1)-1:0] s2_sq;

  assign accept = in_valid && (state_q == ST_RUN);

  add12u_err_stage #(.WIDTH(WIDTH)) u_stage (
    .clk      (clk),
    .rst      (rst),
    .in_valid (accept),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_o     (in_o),
    .s1_valid (s1_valid),
    .s2_valid (s2_valid),
    .s2_d     (s2_d),
    .s2_sq    (s2_sq),
    .s2_ne    (s2_ne)
  );

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    abs_d   = abs_q;
    sq_d    = sq_q;
    wce_d   = wce_q;
    err_d   = err_q;

    if (s2_valid) begin
      abs_d = ABS_W'(sat_add(SAT_W'(abs_q), SAT_W'(s2_d), ABS_W));
      sq_d  = SQ_W'(sat_add(SAT_W'(sq_q), SAT_W'(s2_sq), SQ_W));
      err_d = err_q + CNT_W'(s2_ne);
      if (s2_d > wce_q) wce_d = s2_d;
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        // The pipe is always empty here, so clearing cannot drop a sample.
        if (start) begin
          n_d     = n_samples;
          cnt_d   = '0;
          abs_d   = '0;
          sq_d    = '0;
          wce_d   = '0;
          err_d   = '0;
          state_d = (n_samples == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (accept) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == n_q) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!s1_valid && !s2_valid) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      n_q     <= '0;
      cnt_q   <= '0;
      abs_q   <= '0;
      sq_q    <= '0;
      wce_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      abs_q   <= abs_d;
      sq_q    <= sq_d;
      wce_q   <= wce_d;
      err_q   <= err_d;
    end
  end

  assign in_ready = (state_q == ST_RUN);
  assign busy     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done     = (state_q == ST_DONE);
  assign abs_sum  = abs_q;
  assign sq_sum   = sq_q;
  assign wce      = wce_q;
  assign err_cnt  = err_q;

endmodule

// File: tb/tb_add12u_err_monitor.sv
// Randomized and directed bench for add12u_err_monitor with a behavioural
// reference model compared against the DUT on every falling edge.
module tb_add12u_err_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [23:0] n_samples;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_a, in_b;
  logic [12:0] in_o;
  logic        busy, done;
  logic [39:0] abs_sum;
  logic [55:0] sq_sum;
  logic [12:0] wce;
  logic [23:0] err_cnt;

  add12u_err_monitor dut (
    .clk(clk), .rst(rst), .start(start), .n_samples(n_samples),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_o(in_o),
    .busy(busy), .done(done),
    .abs_sum(abs_sum), .sq_sum(sq_sum), .wce(wce), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  localparam longint unsigned ABS_MAX = (64'd1 << 40) - 64'd1;
  localparam longint unsigned SQ_MAX  = (64'd1 << 56) - 64'd1;

  // Reference model: phase 0 idle, 1 run, 2 drain, 3 done.
  int              m_phase = 0;
  longint unsigned m_n = 0, m_cnt = 0, m_abs = 0, m_sq = 0, m_wce = 0, m_err = 0;
  int              m_drain = 0;
  bit              pv0 = 0, pv1 = 0;
  longint unsigned pd0 = 0, pd1 = 0;
  bit              m_acc;
  longint unsigned m_ex, m_o;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // A sample's error lands in the results two edges after its accept edge;
  // done follows three edges after the last accept.
  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_n = 0; m_cnt = 0;
      m_abs = 0; m_sq = 0; m_wce = 0; m_err = 0;
      pv0 = 0; pv1 = 0; pd0 = 0; pd1 = 0; m_drain = 0;
    end else begin
      if (pv1) begin
        m_abs = (m_abs + pd1 > ABS_MAX) ? ABS_MAX : m_abs + pd1;
        m_sq  = (m_sq + pd1 * pd1 > SQ_MAX) ? SQ_MAX : m_sq + pd1 * pd1;
        if (pd1 != 0) m_err++;
        if (pd1 > m_wce) m_wce = pd1;
      end
      m_acc = (m_phase == 1) && in_valid;
      m_ex  = longint'(in_a) + longint'(in_b);
      m_o   = longint'(in_o);
      pv1 = pv0; pd1 = pd0;
      pv0 = m_acc;
      pd0 = m_acc ? ((m_ex > m_o) ? m_ex - m_o : m_o - m_ex) : 0;
      case (m_phase)
        0, 3: if (start) begin
          m_n = longint'(n_samples); m_cnt = 0;
          m_abs = 0; m_sq = 0; m_wce = 0; m_err = 0;
          m_phase = (n_samples == 0) ? 3 : 1;
        end
        1: if (m_acc) begin
          m_cnt++;
          if (m_cnt == m_n) begin m_phase = 2; m_drain = 0; end
        end
        2: begin
          m_drain++;
          if (m_drain == 3) m_phase = 3;
        end
        default: m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", 64'(in_ready), 64'(m_phase == 1));
      check("busy",     64'(busy),     64'(m_phase == 1 || m_phase == 2));
      check("done",     64'(done),     64'(m_phase == 3));
      check("abs_sum",  64'(abs_sum),  m_abs);
      check("sq_sum",   64'(sq_sum),   m_sq);
      check("wce",      64'(wce),      m_wce);
      check("err_cnt",  64'(err_cnt),  m_err);
    end
  end

  logic [11:0] da[4], db[4];
  logic [12:0] dout[4];

  // kind 0: exact sums, 1: random errors, 2: directed table da/db/dout.
  task automatic do_run(input int n, input int kind, input int pct,
                        input int stop_after, output int sent);
    int cyc;
    sent = 0;
    cyc  = 0;
    @(negedge clk);
    start = 1'b1; n_samples = 24'(n); in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    while (sent < n && sent != stop_after && cyc < 20000) begin
      if (kind == 2) begin
        in_a = da[sent % 4]; in_b = db[sent % 4]; in_o = dout[sent % 4];
      end else begin
        in_a = 12'($urandom);
        in_b = 12'($urandom);
        in_o = {1'b0, in_a} + {1'b0, in_b};
        if (kind == 1 && $urandom_range(0, 1) == 1) in_o = 13'($urandom);
      end
      in_valid = ($urandom_range(0, 99) < pct);
      if (in_valid && in_ready) sent++;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    if (cyc >= 20000) begin
      tests++; fails++;
      $display("FAIL accept_budget: got %0d accepts expected %0d", sent, n);
    end
  endtask

  task automatic wait_done();
    int c = 0;
    while (!done && c < 50) begin
      @(negedge clk);
      c++;
    end
    check("done_reached", 64'(done), 64'd1);
  endtask

  task automatic check_results(input string tag, input longint unsigned e_abs,
                               input longint unsigned e_sq, input longint unsigned e_wce,
                               input longint unsigned e_err);
    check({tag, "_abs"}, 64'(abs_sum), e_abs);
    check({tag, "_sq"},  64'(sq_sum),  e_sq);
    check({tag, "_wce"}, 64'(wce),     e_wce);
    check({tag, "_err"}, 64'(err_cnt), e_err);
  endtask

  initial begin
    int sent;
    rst = 1'b1; start = 1'b0; n_samples = '0; in_valid = 1'b0;
    in_a = '0; in_b = '0; in_o = '0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("rst_ready", 64'(in_ready), 64'd0);
    check("rst_busy",  64'(busy),     64'd0);
    check("rst_done",  64'(done),     64'd0);
    check_results("rst", 0, 0, 0, 0);
    rst = 1'b0;
    @(negedge clk);

    // Exact stream
    do_run(1000, 0, 90, -1, sent);
    wait_done();
    check_results("exact", 0, 0, 0, 0);

    // in_valid high outside RUN must be ignored
    in_valid = 1'b1; in_a = 12'h123; in_b = 12'h456; in_o = 13'h0;
    repeat (5) @(negedge clk);
    in_valid = 1'b0;
    check_results("ignore", 0, 0, 0, 0);

    // Single known error
    da[0] = 12'hFFF; db[0] = 12'hFFF; dout[0] = 13'h1FF8;
    do_run(1, 2, 100, -1, sent);
    wait_done();
    check_results("single", 6, 36, 6, 1);

    // Overestimate plus exact sample
    da[0] = 12'h001; db[0] = 12'h001; dout[0] = 13'h0028;
    da[1] = 12'h100; db[1] = 12'h001; dout[1] = 13'h0101;
    do_run(2, 2, 100, -1, sent);
    wait_done();
    check_results("over", 38, 1444, 38, 1);

    // Handshake with pseudo-random valid
    do_run(5, 1, 40, -1, sent);
    check("hs_accepts", 64'(sent), 64'd5);
    wait_done();

    // Random error run
    do_run(200, 1, 70, -1, sent);
    wait_done();

    // Directed run, then zero run, then back-to-back re-arm
    da[0] = 12'h005; db[0] = 12'h003; dout[0] = 13'h000A;
    da[1] = 12'h010; db[1] = 12'h020; dout[1] = 13'h002C;
    do_run(2, 2, 100, -1, sent);
    wait_done();
    check_results("pre0", 6, 20, 4, 2);
    do_run(0, 0, 100, -1, sent);
    check("zero_done", 64'(done), 64'd1);
    check_results("zero", 0, 0, 0, 0);
    da[0] = 12'h7FF; db[0] = 12'h001; dout[0] = 13'h0803;
    da[1] = 12'h000; db[1] = 12'h000; dout[1] = 13'h0000;
    do_run(2, 2, 100, -1, sent);
    wait_done();
    check_results("rearm", 3, 9, 3, 1);

    // Reset mid-run after 3 of 10 accepts
    do_run(10, 1, 100, 3, sent);
    rst = 1'b1;
    @(negedge clk);
    check("mid_ready", 64'(in_ready), 64'd0);
    check("mid_busy",  64'(busy),     64'd0);
    check("mid_done",  64'(done),     64'd0);
    check_results("mid", 0, 0, 0, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_results("mid_idle", 0, 0, 0, 0);
    do_run(1, 0, 100, -1, sent);
    wait_done();
    check_results("post_rst", 0, 0, 0, 0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
